// File: rtl/nmr_bstrm_pkg.sv
// Shared types and constants for the bitstream sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nmr_bstrm_pkg;

  localparam int DEF_SRAM_ADDR_WIDTH = 8;
  localparam int DEF_SRAM_DAT_WIDTH  = 32;
  localparam int DEF_LOOP_WIDTH      = 16;

  // Word buffer between the reader and the consumer
  localparam int BUF_DEPTH     = 2;
  localparam int BUF_CNT_WIDTH = $clog2(BUF_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/nmr_bstrm_seq_fifo2.sv
// Two-entry in-order word buffer with registered head word and head valid.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push must not be issued when full; pop is ignored when empty.
module nmr_bstrm_seq_fifo2
  import nmr_bstrm_pkg::*;
#(
  parameter int DW = DEF_SRAM_DAT_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [BUF_CNT_WIDTH-1:0] o_count,
  output logic [DW-1:0]            o_head_dat,
  output logic                     o_head_vld
);

  // Entry 0 is always the head, so the consumer-facing outputs come straight from flops
  logic          r_vld0;
  logic          r_vld1;
  logic [DW-1:0] r_dat0;
  logic [DW-1:0] r_dat1;
  logic          w_pop;

  assign w_pop      = i_pop & r_vld0;
  assign o_full     = r_vld1;
  assign o_empty    = ~r_vld0;
  assign o_count    = BUF_CNT_WIDTH'(r_vld0) + BUF_CNT_WIDTH'(r_vld1);
  assign o_head_dat = r_dat0;
  assign o_head_vld = r_vld0;

  // Shift-register storage: pops move entry 1 forward, pushes fill the first free slot
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_dat0 <= '0;
      r_dat1 <= '0;
    end else if (i_flush) begin
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
    end else begin
      case ({w_pop, i_push})
        2'b11: begin
          if (r_vld1) begin
            r_dat0 <= r_dat1;
            r_dat1 <= i_push_dat;
          end else begin
            r_dat0 <= i_push_dat;
          end
        end
        2'b10: begin
          r_dat0 <= r_dat1;
          r_vld0 <= r_vld1;
          r_vld1 <= 1'b0;
        end
        2'b01: begin
          if (!r_vld0) begin
            r_dat0 <= i_push_dat;
            r_vld0 <= 1'b1;
          end else begin
            r_dat1 <= i_push_dat;
            r_vld1 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nmr_bstrm_seq_ctrl.sv
// Walks the SRAM reader over [begin,end] for LOOP_CNT+1 passes, buffering words for the consumer.
// Latency: one reader round trip plus one ISSUE and one NEXT cycle per word; DONE one cycle after the last ack.
// Backpressure: no new read is issued while buffered plus in-flight words would exceed two. Optional ABORT port under NMR_BSTRM_SEQ_ABORT_EN.
module nmr_bstrm_seq_ctrl
  import nmr_bstrm_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
  parameter int SRAM_DAT_WIDTH  = DEF_SRAM_DAT_WIDTH,
  parameter int LOOP_WIDTH      = DEF_LOOP_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [SRAM_ADDR_WIDTH-1:0] ADDR_BEGIN,
  input  logic [SRAM_ADDR_WIDTH-1:0] ADDR_END,
  input  logic [LOOP_WIDTH-1:0]      LOOP_CNT,
`ifdef NMR_BSTRM_SEQ_ABORT_EN
  input  logic                       ABORT,
`endif
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       ERR,
  output logic                       RD_START,
  output logic [SRAM_ADDR_WIDTH-1:0] RD_ADDR,
  input  logic                       RD_SYS_RDY,
  input  logic                       RD_DATA_RDY,
  input  logic [SRAM_DAT_WIDTH-1:0]  RD_DATA,
  output logic [SRAM_DAT_WIDTH-1:0]  WORD_OUT,
  output logic                       WORD_VLD,
  input  logic                       WORD_ACK
);

  state_t                     r_state;
  state_t                     w_next;
  logic [SRAM_ADDR_WIDTH-1:0] r_beg;
  logic [SRAM_ADDR_WIDTH-1:0] r_end;
  logic [SRAM_ADDR_WIDTH-1:0] r_cur;
  logic [LOOP_WIDTH-1:0]      r_loop;
  logic [LOOP_WIDTH-1:0]      r_pass;
  logic [SRAM_ADDR_WIDTH-1:0] r_rd_addr;
  logic                       r_rd_start;
  logic                       r_err;

  logic                       w_abort;
  logic                       w_done;
  logic                       w_start_ok;
  logic                       w_start_err;
  logic                       w_issue;
  logic                       w_push;
  logic                       w_full;
  logic                       w_empty;
  logic [BUF_CNT_WIDTH-1:0]   w_cnt;

  // Only one read is ever outstanding and ISSUE is never entered with one in flight,
  // so buffer occupancy alone bounds buffered plus in-flight words.
  assign w_start_ok  = (r_state == ST_IDLE) && START && (ADDR_END >= ADDR_BEGIN);
  assign w_start_err = (r_state == ST_IDLE) && START && (ADDR_END <  ADDR_BEGIN);
  assign w_issue     = (r_state == ST_ISSUE) && RD_SYS_RDY && !w_abort &&
                       (w_cnt < BUF_CNT_WIDTH'(BUF_DEPTH));
  assign w_push      = (r_state == ST_WAIT) && RD_DATA_RDY && !w_abort && !w_full;

  assign BUSY     = (r_state != ST_IDLE);
  assign DONE     = w_done;
  assign ERR      = r_err;
  assign RD_START = r_rd_start;
  assign RD_ADDR  = r_rd_addr;

`ifdef NMR_BSTRM_SEQ_ABORT_EN
  logic r_abort;

  // Remember an abort until the run has wound back to IDLE
  always_ff @(posedge CLK) begin
    if (RST)                                    r_abort <= 1'b0;
    else if (w_next == ST_IDLE)                 r_abort <= 1'b0;
    else if (ABORT && (r_state != ST_IDLE))     r_abort <= 1'b1;
  end

  assign w_abort = r_abort | (ABORT && (r_state != ST_IDLE));
`else
  assign w_abort = 1'b0;
`endif

  nmr_bstrm_seq_fifo2 #(
    .DW (SRAM_DAT_WIDTH)
  ) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .i_push     (w_push),
    .i_push_dat (RD_DATA),
    .i_pop      (WORD_ACK),
    .i_flush    (w_abort),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_cnt),
    .o_head_dat (WORD_OUT),
    .o_head_vld (WORD_VLD)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and DONE
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_next = ST_ISSUE;
      ST_ISSUE: begin
        if (w_abort)      w_next = ST_DRAIN;
        else if (w_issue) w_next = ST_WAIT;
      end
      // The outstanding read must land before leaving, even when aborting
      ST_WAIT:  if (RD_DATA_RDY) w_next = w_abort ? ST_DRAIN : ST_NEXT;
      ST_NEXT: begin
        if (w_abort)                            w_next = ST_DRAIN;
        else if (r_cur < r_end || r_pass < r_loop) w_next = ST_ISSUE;
        else                                    w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Run configuration, address/pass walk and reader request
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_beg      <= '0;
      r_end      <= '0;
      r_cur      <= '0;
      r_loop     <= '0;
      r_pass     <= '0;
      r_rd_addr  <= '0;
      r_rd_start <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_start <= w_issue;
      r_err      <= w_start_err;
      if (w_issue) r_rd_addr <= r_cur;
      if (w_start_ok) begin
        r_beg  <= ADDR_BEGIN;
        r_end  <= ADDR_END;
        r_loop <= LOOP_CNT;
        r_cur  <= ADDR_BEGIN;
        r_pass <= '0;
      end else if (r_state == ST_NEXT && !w_abort) begin
        if (r_cur < r_end) begin
          r_cur <= r_cur + SRAM_ADDR_WIDTH'(1);
        end else if (r_pass < r_loop) begin
          r_pass <= r_pass + LOOP_WIDTH'(1);
          r_cur  <= r_beg;
        end
      end
    end
  end

endmodule
